shift_add_accum_2b: RTL and testbench
=====================================

Name: shift_add_accum_2b

Overview:
- Sequential shift-add accumulator directly downstream of the combinational 2b x 2b unsigned multiplier in the temporal precision-scalable MAC.
- Sequences the 2-bit operand slices fed to the multiplier and accepts one 4-bit partial product per beat.
- Shifts each partial product by its slice significance and accumulates full 8b/4b/2b products over a dot product of programmable length.
- Presents the final sum on a valid/ready output.

Parameters:
ACC_W, 24, accumulator/output width; default holds 256 x (255 x 255) without overflow
LEN_W, 8, width of the len_m1 field (products per dot product, minus 1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a dot product; sampled only in IDLE
prec  input  2  precision, latched at start: 0=8b (4 slices), 1=4b (2 slices), 2=2b (1 slice), 3=reserved (treated as 2b)
len_m1  input  LEN_W  number of products minus 1, latched at start
a_sel  output  2  activation slice index for upstream slice mux
w_sel  output  2  weight slice index for upstream slice mux
in_valid  input  1  prod is valid
in_ready  output  1  block accepts prod this cycle
prod  input  4  unsigned 2b x 2b partial product
busy  output  1  state != IDLE
out_valid  output  1  out_sum is valid
out_ready  input  1  consumer accepts out_sum
out_sum  output  ACC_W  accumulated dot product

Behaviour:
- Reset (async, any state): state=IDLE, acc=0, a_sel=0, w_sel=0, product counter=0, out_valid=0, in_ready=0, busy=0. Reset mid-RUN discards the partial sum; no output is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches prec and len_m1, clears acc, a_sel, w_sel and the counter; next state RUN.
  - start is ignored in RUN and DONE.
- RUN:
  - in_ready=1.
  - A beat occurs when in_valid & in_ready: acc <= acc + (zero-extended prod << 2*(a_sel+w_sel)). Maximum shift is 12; the term is 16 bits.
  - Slice order: w_sel increments fastest; on w_sel=S-1 it wraps to 0 and a_sel increments; on a_sel=S-1 and w_sel=S-1 both wrap to 0 and the product counter increments. S=4/2/1 per prec.
  - Without a beat, all state holds. in_valid low is a stall, not an error.
  - a_sel/w_sel always show the slice pair for the next beat. They are registered and change only after a beat.
  - Last beat (counter=len_m1, a_sel=w_sel=S-1) goes to DONE.
  - Beats per dot product = (len_m1+1) x S x S.
- DONE:
  - in_ready=0, out_valid=1, out_sum=acc (registered, stable while out_valid).
  - On out_ready=1 go to IDLE; out_valid drops next cycle.
  - A new start is accepted at the earliest one cycle after the handshake, once back in IDLE.
- out_sum is driven from acc in all states and is meaningful only while out_valid=1.
- Arithmetic is unsigned. On overflow of ACC_W the sum wraps modulo 2^ACC_W unless the optional feature is enabled.
- Latency:
  - From start to the first in_ready: 1 cycle.
  - From the last beat to out_valid: 1 cycle.

Optional Feature:
- Macro: SHIFT_ADD_ACCUM_SAT_EN.
- Defined:
  - Each add whose true result exceeds 2^ACC_W-1 clamps acc to all ones.
  - acc stays clamped until the next start.
  - A sticky ovf bit is set; it is exposed as extra output port ovf (1 bit), valid with out_valid and cleared at start/reset.
- Undefined: wrap-around, and no ovf port exists.

Test Plan:
- prec=2, len_m1=0, one beat prod=3 -> 1 beat accepted, a_sel=w_sel=0 throughout, out_valid 1 cycle after the beat, out_sum=3.
- prec=0, len_m1=0, upstream multiplies slices of a=0xFF, w=0xFF (every prod=9) -> 16 beats with (a_sel,w_sel) sequence (0,0),(0,1)..(3,3), out_sum=65025.
- prec=1, len_m1=2, operands (a,w) = (15,15),(7,3),(0,9) with random in_valid gaps -> 12 beats, values unaffected by stalls, out_sum=225+21+0=246.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_sum=246 stable, in_ready=0, start pulses ignored. Then out_ready=1 -> IDLE and busy=0 next cycle.
- rst asserted asynchronously mid-RUN after 7 of 16 beats -> all outputs to reset values immediately. The following prec=2 run with prod=1 gives out_sum=1 (no stale partial sum).
- ACC_W=16 with SHIFT_ADD_ACCUM_SAT_EN, prec=0, len_m1=1, both products 255x255 -> out_sum=0xFFFF, ovf=1. Without the macro -> out_sum=(130050 mod 65536)=64514.

Source files
------------

// File: rtl/shift_add_accum_2b.sv
// Shift-add accumulator behind a 2b x 2b multiplier: sequences operand slices and sums shifted partial products.
// Optional saturation with sticky ovf port when SHIFT_ADD_ACCUM_SAT_EN is defined.
module shift_add_accum_2b #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       prec,
    input  logic [LEN_W-1:0] len_m1,
    output logic [1:0]       a_sel,
    output logic [1:0]       w_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       prod,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SHIFT_ADD_ACCUM_SAT_EN
    output logic             ovf,
`endif
    output logic [ACC_W-1:0] out_sum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [ACC_W-1:0] acc, acc_d, term_x;
    logic [LEN_W-1:0] cnt, len_q;
    logic [1:0]       prec_q, smax;
    logic [2:0]       sig;
    logic [15:0]      term;
    logic             beat, w_wrap, a_wrap, last;

    always_comb begin
        unique case (prec_q)
            2'd0:    smax = 2'd3;
            2'd1:    smax = 2'd1;
            default: smax = 2'd0;
        endcase
    end

    // Shift by 2 bits per unit of combined slice significance
    assign sig    = 3'(a_sel) + 3'(w_sel);
    assign term   = 16'(prod) << {sig, 1'b0};
    assign term_x = ACC_W'(term);

`ifdef SHIFT_ADD_ACCUM_SAT_EN
    logic [ACC_W:0] sum;
    assign sum   = {1'b0, acc} + {1'b0, term_x};
    assign acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    assign acc_d = acc + term_x;
`endif

    assign beat   = (state == RUN) && in_valid;
    assign w_wrap = (w_sel == smax);
    assign a_wrap = (a_sel == smax);
    assign last   = beat && w_wrap && a_wrap && (cnt == len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                in_ready = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            len_q  <= '0;
            prec_q <= '0;
            a_sel  <= '0;
            w_sel  <= '0;
        end else if (state == IDLE && start) begin
            acc    <= '0;
            cnt    <= '0;
            len_q  <= len_m1;
            prec_q <= prec;
            a_sel  <= '0;
            w_sel  <= '0;
        end else if (beat) begin
            acc <= acc_d;
            if (w_wrap) begin
                w_sel <= '0;
                if (a_wrap) begin
                    a_sel <= '0;
                    cnt   <= cnt + LEN_W'(1);
                end else begin
                    a_sel <= a_sel + 2'd1;
                end
            end else begin
                w_sel <= w_sel + 2'd1;
            end
        end
    end

`ifdef SHIFT_ADD_ACCUM_SAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         ovf <= 1'b0;
        else if (state == IDLE && start) ovf <= 1'b0;
        else if (beat && sum[ACC_W])     ovf <= 1'b1;
    end
`endif

    assign out_sum = acc;

endmodule

// File: tb/tb_shift_add_accum_2b.sv
// Directed bench for shift_add_accum_2b with an expected-sum queue.
module tb_shift_add_accum_2b;

    localparam int ACC_W = 16;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       prec = 2'd0;
    logic [LEN_W-1:0] len_m1 = '0;
    logic [1:0]       a_sel, w_sel;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       prod = 4'd0;
    logic             busy, out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
`ifdef SHIFT_ADD_ACCUM_SAT_EN
    logic             ovf;
`endif

    int checks = 0;
    int failures = 0;
    int expq[$];

    shift_add_accum_2b #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .prec(prec),
        .len_m1(len_m1), .a_sel(a_sel), .w_sel(w_sel),
        .in_valid(in_valid), .in_ready(in_ready), .prod(prod),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
`ifdef SHIFT_ADD_ACCUM_SAT_EN
        .ovf(ovf),
`endif
        .out_sum(out_sum)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int slice(input int v, input int s);
        return (v >> (2 * s)) & 3;
    endfunction

    task automatic run_dot(input int p, input int n,
                           input int av[4], input int wv[4],
                           input int gapmax, input int hold,
                           input int exp_ovf);
        int s, tot, e, g, k;
        s = (p == 0) ? 4 : (p == 1) ? 2 : 1;
        tot = 0;
        for (int i = 0; i < n; i++) tot += av[i] * wv[i];
`ifdef SHIFT_ADD_ACCUM_SAT_EN
        e = (tot > 65535) ? 65535 : tot;
`else
        e = tot % 65536;
`endif
        expq.push_back(e);
        prec = 2'(p);
        len_m1 = LEN_W'(n - 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_lat_in_ready", int'(in_ready), 1);
        for (int i = 0; i < n; i++)
            for (int as = 0; as < s; as++)
                for (int ws = 0; ws < s; ws++) begin
                    g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
                    for (int j = 0; j < g; j++) step();
                    if (a_sel !== 2'(as) || w_sel !== 2'(ws) || !in_ready)
                        check("slice_seq", {in_ready, a_sel, w_sel},
                              {1'b1, 2'(as), 2'(ws)});
                    in_valid = 1'b1;
                    prod = 4'(slice(av[i], as) * slice(wv[i], ws));
                    step();
                    in_valid = 1'b0;
                    prod = 4'($urandom_range(0, 15));
                end
        check("out_lat", int'(out_valid), 1);
        k = 0;
        while (!out_valid && k < 8) begin
            step();
            k++;
        end
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            prec = 2'd2;
            step();
            start = 1'b0;
            check("hold_valid", int'(out_valid), 1);
            check("hold_sum", int'(out_sum), e);
            check("hold_in_ready", int'(in_ready), 0);
        end
        if (expq.size() > 0) check("out_sum", int'(out_sum), expq.pop_front());
`ifdef SHIFT_ADD_ACCUM_SAT_EN
        check("ovf", int'(ovf), exp_ovf);
`else
        if (exp_ovf > 1) check("ovf_arg", exp_ovf, 0);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_valid", int'(out_valid), 0);
        check("post_busy", int'(busy), 0);
    endtask

    initial begin
        int ov;
        step();
        step();
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_sel", {a_sel, w_sel}, 0);
        check("rst_sum", int'(out_sum), 0);
        rst = 1'b0;
        step();
        check("idle_in_ready", int'(in_ready), 0);

        run_dot(2, 1, '{3, 0, 0, 0}, '{1, 0, 0, 0}, 0, 0, 0);
        run_dot(0, 1, '{255, 0, 0, 0}, '{255, 0, 0, 0}, 0, 0, 0);
        run_dot(1, 3, '{15, 7, 0, 0}, '{15, 3, 9, 0}, 3, 5, 0);

        prec = 2'd0;
        len_m1 = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            prod = 4'd9;
            step();
        end
        in_valid = 1'b0;
        check("pre_rst_sel", {a_sel, w_sel}, 7);
        #3;
        rst = 1'b1;
        #1;
        check("async_busy", int'(busy), 0);
        check("async_in_ready", int'(in_ready), 0);
        check("async_valid", int'(out_valid), 0);
        check("async_sel", {a_sel, w_sel}, 0);
        check("async_sum", int'(out_sum), 0);
        step();
        rst = 1'b0;
        step();
        run_dot(2, 1, '{1, 0, 0, 0}, '{1, 0, 0, 0}, 0, 0, 0);

`ifdef SHIFT_ADD_ACCUM_SAT_EN
        ov = 1;
`else
        ov = 0;
`endif
        run_dot(0, 2, '{255, 255, 0, 0}, '{255, 255, 0, 0}, 0, 0, ov);
        check("queue_empty", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
